// File: rtl/keystone_input_framer.sv
// Input framer for the keystone core: a first-word-fall-through FIFO that tags every
// accepted pixel beat with its (x, y) position and tracks line-length errors and frames.
module keystone_input_framer #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 8,
    parameter int COORD_W = 12
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               clock_en,
    input  logic [DATA_W-1:0]  pixel_stream_in,
    input  logic               valid_in,
    output logic               ready_out,
    input  logic               start_of_frame_in,
    input  logic               end_of_line_in,
    output logic [DATA_W-1:0]  pixel_stream_out,
    output logic               valid_out,
    input  logic               ready_in,
    output logic               start_of_frame_out,
    output logic               end_of_line_out,
    output logic [COORD_W-1:0] x_out,
    output logic [COORD_W-1:0] y_out,
    input  logic [COORD_W-1:0] line_width,
    input  logic               clear_status,
    output logic               early_eol_err,
    output logic               late_eol_err,
    output logic [15:0]        frame_count
);
    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W   = $clog2(DEPTH + 1);
    localparam int ENTRY_W = DATA_W + 2 + 2 * COORD_W;

    logic [ENTRY_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;
    logic [COORD_W-1:0] x_next;
    logic [COORD_W-1:0] y_next;
    logic [COORD_W-1:0] tag_x;
    logic [COORD_W-1:0] tag_y;
    logic [COORD_W-1:0] lw_last;
    logic               push;
    logic               pop;
    logic               set_early;
    logic               set_late;

    logic [DATA_W-1:0]  head_data;
    logic               head_sof;
    logic               head_eol;
    logic [COORD_W-1:0] head_x;
    logic [COORD_W-1:0] head_y;

    // Reset blocks acceptance in the same cycle so nothing sneaks in while it is held.
    assign ready_out = (count < CNT_W'(DEPTH)) && clock_en && !reset;
    assign valid_out = (count != '0) && clock_en;
    assign push      = valid_in && ready_out;
    assign pop       = valid_out && ready_in;
    assign lw_last   = line_width - COORD_W'(1);

    always_comb begin
        tag_x     = start_of_frame_in ? '0 : x_next;
        tag_y     = start_of_frame_in ? '0 : y_next;
        set_early = push && end_of_line_in && (tag_x != lw_last);
        set_late  = push && !end_of_line_in && (tag_x == lw_last);
    end

    always_ff @(posedge clock) begin
        if (push) begin
            mem[wr_ptr] <= {pixel_stream_in, start_of_frame_in, end_of_line_in, tag_x, tag_y};
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            x_next        <= '0;
            y_next        <= '0;
            frame_count   <= '0;
            early_eol_err <= 1'b0;
            late_eol_err  <= 1'b0;
        end else if (clock_en) begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
                if (end_of_line_in) begin
                    x_next <= '0;
                    y_next <= tag_y + COORD_W'(1);
                end else begin
                    x_next <= tag_x + COORD_W'(1);
                    y_next <= tag_y;
                end
                if (start_of_frame_in) begin
                    frame_count <= frame_count + 16'd1;
                end
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
            // A new error in the clearing cycle keeps its flag set.
            early_eol_err <= (early_eol_err && !clear_status) || set_early;
            late_eol_err  <= (late_eol_err && !clear_status) || set_late;
        end
    end

    assign {head_data, head_sof, head_eol, head_x, head_y} = mem[rd_ptr];

    always_comb begin
        pixel_stream_out   = '0;
        start_of_frame_out = 1'b0;
        end_of_line_out    = 1'b0;
        x_out              = '0;
        y_out              = '0;
        if (valid_out) begin
            pixel_stream_out   = head_data;
            start_of_frame_out = head_sof;
            end_of_line_out    = head_eol;
            x_out              = head_x;
            y_out              = head_y;
        end
    end

endmodule

// File: tb/tb_keystone_input_framer.sv
// Directed bench for keystone_input_framer: framing, back-pressure, line errors,
// reset mid-stream, clock-enable freeze and frame counter wrap.
module tb_keystone_input_framer;
    localparam int DATA_W  = 64;
    localparam int DEPTH   = 8;
    localparam int COORD_W = 12;

    logic               clock;
    logic               reset;
    logic               clock_en;
    logic [DATA_W-1:0]  pixel_stream_in;
    logic               valid_in;
    logic               ready_out;
    logic               start_of_frame_in;
    logic               end_of_line_in;
    logic [DATA_W-1:0]  pixel_stream_out;
    logic               valid_out;
    logic               ready_in;
    logic               start_of_frame_out;
    logic               end_of_line_out;
    logic [COORD_W-1:0] x_out;
    logic [COORD_W-1:0] y_out;
    logic [COORD_W-1:0] line_width;
    logic               clear_status;
    logic               early_eol_err;
    logic               late_eol_err;
    logic [15:0]        frame_count;

    int checks = 0;
    int errors = 0;

    keystone_input_framer #(
        .DATA_W  (DATA_W),
        .DEPTH   (DEPTH),
        .COORD_W (COORD_W)
    ) dut (
        .clock              (clock),
        .reset              (reset),
        .clock_en           (clock_en),
        .pixel_stream_in    (pixel_stream_in),
        .valid_in           (valid_in),
        .ready_out          (ready_out),
        .start_of_frame_in  (start_of_frame_in),
        .end_of_line_in     (end_of_line_in),
        .pixel_stream_out   (pixel_stream_out),
        .valid_out          (valid_out),
        .ready_in           (ready_in),
        .start_of_frame_out (start_of_frame_out),
        .end_of_line_out    (end_of_line_out),
        .x_out              (x_out),
        .y_out              (y_out),
        .line_width         (line_width),
        .clear_status       (clear_status),
        .early_eol_err      (early_eol_err),
        .late_eol_err       (late_eol_err),
        .frame_count        (frame_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [63:0] d, input logic sof, input logic eol);
        valid_in          = v;
        pixel_stream_in   = d;
        start_of_frame_in = sof;
        end_of_line_in    = eol;
    endtask

    initial begin
        reset        = 1'b1;
        clock_en     = 1'b1;
        ready_in     = 1'b0;
        line_width   = 12'd4;
        clear_status = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 1'b0);

        // Reset state, sampled while reset is still held
        cyc();
        cyc();
        #1;
        check("rst_ready", ready_out, 0);
        check("rst_valid", valid_out, 0);
        check("rst_frame_count", frame_count, 0);
        check("rst_flags", {early_eol_err, late_eol_err}, 0);
        check("rst_data", pixel_stream_out, 0);
        check("rst_xy", {x_out, y_out}, 0);
        reset = 1'b0;
        cyc();

        // 3 lines x 4 beats, core always ready
        ready_in = 1'b1;
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 64'(k), k == 0, (k % 4) == 3);
            #1;
            if (k > 0) begin
                check("frm_data", pixel_stream_out, 64'(k - 1));
                check("frm_xy", {x_out, y_out}, {12'((k - 1) % 4), 12'((k - 1) / 4)});
                check("frm_flags", {start_of_frame_out, end_of_line_out},
                      {1'(k == 1), 1'(((k - 1) % 4) == 3)});
            end
            cyc();
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        #1;
        check("frm_last", {pixel_stream_out[15:0], x_out, y_out, end_of_line_out},
              {16'd11, 12'd3, 12'd2, 1'b1});
        cyc();
        #1;
        check("frm_empty", valid_out, 0);
        check("frm_errs", {early_eol_err, late_eol_err}, 0);
        check("frm_count", frame_count, 1);

        // Back-pressure: fill all 8 entries, 9th beat refused
        ready_in   = 1'b0;
        line_width = 12'd100;
        for (int k = 0; k < 9; k++) begin
            drive(1'b1, 64'(100 + k), 1'b0, 1'b0);
            #1;
            check("bp_ready", ready_out, k < 8);
            cyc();
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        ready_in = 1'b1;
        for (int j = 0; j < 8; j++) begin
            #1;
            check("bp_valid", valid_out, 1);
            check("bp_data", pixel_stream_out, 64'(100 + j));
            check("bp_xy", {x_out, y_out}, {12'(j), 12'd3});
            cyc();
        end
        #1;
        check("bp_drained", valid_out, 0);

        // Early EOL on the third beat of a line
        line_width = 12'd4;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 64'(300 + k), k == 0, k == 2);
            #1;
            check("early_pre", early_eol_err, 0);
            cyc();
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        #1;
        check("early_set", {early_eol_err, late_eol_err}, 2'b10);
        cyc();
        cyc();
        cyc();
        check("early_sticky", early_eol_err, 1);
        clear_status = 1'b1;
        cyc();
        clear_status = 1'b0;
        #1;
        check("early_clear", early_eol_err, 0);
        check("early_frames", frame_count, 2);

        // Late EOL: five beats, no EOL
        for (int k = 0; k < 5; k++) begin
            drive(1'b1, 64'(400 + k), k == 0, 1'b0);
            #1;
            check("late_flag", late_eol_err, k == 4);
            if (k > 0) check("late_x", x_out, 64'(k - 1));
            cyc();
        end
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        #1;
        check("late_x5", {valid_out, x_out, y_out}, {1'b1, 12'd4, 12'd0});
        check("late_only", {early_eol_err, late_eol_err}, 2'b01);
        cyc();
        clear_status = 1'b1;
        cyc();
        clear_status = 1'b0;
        #1;
        check("late_clear", late_eol_err, 0);
        check("late_frames", frame_count, 3);

        // Half-full steady streaming, then reset mid-stream
        line_width = 12'd100;
        ready_in   = 1'b0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 64'(200 + k), k == 0, 1'b0);
            cyc();
        end
        ready_in = 1'b1;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 64'(204 + i), 1'b0, 1'b0);
            #1;
            check("hf_ready", {ready_out, valid_out}, 2'b11);
            check("hf_data", pixel_stream_out, 64'(200 + i));
            cyc();
        end
        check("hf_frames", frame_count, 4);
        reset = 1'b1;
        drive(1'b1, 64'd210, 1'b0, 1'b0);
        cyc();
        #1;
        check("mid_rst_valid", {valid_out, ready_out}, 0);
        check("mid_rst_frames", frame_count, 0);
        check("mid_rst_out", {pixel_stream_out[15:0], x_out, y_out}, 0);
        reset = 1'b0;
        drive(1'b1, 64'h55, 1'b0, 1'b0);
        cyc();
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        #1;
        check("post_rst_beat", {valid_out, pixel_stream_out[15:0], x_out, y_out},
              {1'b1, 16'h55, 12'd0, 12'd0});
        cyc();

        // clock_en freeze with pending traffic and a clear pulse
        ready_in = 1'b0;
        drive(1'b1, 64'h77, 1'b0, 1'b0);
        cyc();
        clock_en     = 1'b0;
        clear_status = 1'b1;
        ready_in     = 1'b1;
        drive(1'b1, 64'h88, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("frz_ready", {ready_out, valid_out}, 0);
            check("frz_data", pixel_stream_out, 0);
            cyc();
        end
        clock_en     = 1'b1;
        clear_status = 1'b0;
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        #1;
        check("frz_kept", {valid_out, pixel_stream_out[15:0], x_out},
              {1'b1, 16'h77, 12'd1});
        cyc();
        #1;
        check("frz_no_accept", valid_out, 0);
        check("frz_frames", frame_count, 0);

        // Frame counter wrap: 65535 SOF beats, then one more
        line_width = 12'd1;
        ready_in   = 1'b1;
        drive(1'b1, 64'd1, 1'b1, 1'b1);
        repeat (65535) cyc();
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        #1;
        check("wrap_max", frame_count, 16'hFFFF);
        check("wrap_errs", {early_eol_err, late_eol_err}, 0);
        drive(1'b1, 64'd2, 1'b1, 1'b1);
        cyc();
        drive(1'b0, 64'd0, 1'b0, 1'b0);
        #1;
        check("wrap_zero", frame_count, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/keystone_input_framer.md
KEYSTONE_INPUT_FRAMER -- requirements
Module: keystone_input_framer

Interface
REQ-001 SHALL have parameter DATA_W, default 64: pixel beat width in bits.
REQ-002 SHALL have parameter DEPTH, default 8: number of FIFO entries, a power of two and at least 2.
REQ-003 SHALL have parameter COORD_W, default 12: width of the x/y coordinate fields.
REQ-004 SHALL have the following ports (clock and reset first):
- clock  in  1  single clock; all logic is on the rising edge.
- reset  in  1  synchronous, active-high reset.
- clock_en  in  1  global enable; 0 freezes all state.
- pixel_stream_in  in  DATA_W  upstream pixel beat.
- valid_in  in  1  upstream beat valid.
- ready_out  out  1  block can accept a beat.
- start_of_frame_in  in  1  beat is the first pixel of a frame.
- end_of_line_in  in  1  beat is the last pixel of a line.
- pixel_stream_out  out  DATA_W  beat to the keystone core.
- valid_out  out  1  output beat valid.
- ready_in  in  1  keystone core accepts the beat.
- start_of_frame_out  out  1  SOF flag of the output beat.
- end_of_line_out  out  1  EOL flag of the output beat.
- x_out  out  COORD_W  column of the output beat.
- y_out  out  COORD_W  row of the output beat.
- line_width  in  COORD_W  expected pixels per line; must be at least 1.
- clear_status  in  1  one-cycle pulse that clears the sticky flags.
- early_eol_err  out  1  sticky flag: EOL arrived before line_width pixels.
- late_eol_err  out  1  sticky flag: line_width pixels passed with no EOL.
- frame_count  out  16  number of accepted SOF beats, wraps at 2^16.

Function
REQ-005 The block SHALL be a first-word-fall-through FIFO of DEPTH entries, each holding {data, sof, eol, x, y}.
REQ-006 An input beat SHALL be accepted when valid_in && ready_out && clock_en; ready_out SHALL equal (count < DEPTH) && clock_en.
REQ-007 An output beat SHALL be popped when valid_out && ready_in && clock_en; valid_out SHALL equal (count != 0) && clock_en.
REQ-008 Push and pop in the same cycle SHALL leave count unchanged; push is never possible when full.
REQ-009 Latency SHALL be one cycle: a beat accepted in cycle N into an empty FIFO SHALL appear with valid_out=1 in cycle N+1.
REQ-010 Once valid_out=1, valid_out and all output fields SHALL stay stable until the beat is popped.
REQ-011 While valid_out=0, pixel_stream_out, start_of_frame_out, end_of_line_out, x_out and y_out SHALL be 0.
REQ-012 Coordinate tracking SHALL use x_next and y_next; both are 0 after reset.
REQ-013 An accepted beat with SOF SHALL be tagged x=0, y=0; other beats SHALL be tagged x_next, y_next.
REQ-014 After an accepted beat tagged (x, y):
- with EOL: x_next=0 and y_next=y+1, wrapping modulo 2^COORD_W;
- without EOL: x_next=x+1, wrapping, and y_next=y.
REQ-015 An accepted EOL beat with tagged x != line_width-1 SHALL set early_eol_err.
REQ-016 An accepted non-EOL beat with tagged x == line_width-1 SHALL set late_eol_err.
REQ-017 A beat that is both SOF and EOL SHALL apply the SOF tagging rule first, then the EOL checks and updates.
REQ-018 An accepted SOF beat SHALL increment frame_count, wrapping 0xFFFF -> 0x0000.
REQ-019 clear_status SHALL clear both sticky flags in the next cycle. If an error condition occurs in the same cycle, the flag SHALL end set (set wins).
REQ-020 When clock_en=0, no state SHALL change, including FIFO contents, counters, flags and clear_status.

Reset
REQ-021 When reset=1 at a clock edge, count, the pointers, x_next, y_next, frame_count, early_eol_err and late_eol_err SHALL all be set to 0.
REQ-022 Reset SHALL override clock_en and all traffic. Every output SHALL be 0 in the cycle after reset, including ready_out=0 and valid_out=0.
REQ-023 When reset is asserted mid-frame, all buffered beats SHALL be discarded. The first beat accepted after reset and not flagged SOF SHALL be tagged x=0, y=0.

Verification
REQ-024 The bench SHALL cover these directed scenarios:
- line_width=4; frame of 3 lines x 4 beats, ready_in=1 -> output coords (0,0)..(3,2), EOL on x=3, flags 0, frame_count=1.
- ready_in=0; push 9 beats -> ready_out drops after the 8th beat; then ready_in=1 -> 8 beats come out in order with no loss or duplication.
- line_width=4; EOL on the 3rd beat -> early_eol_err=1 and stays set; clear_status pulse -> flag 0 the next cycle.
- line_width=4; 5 beats with no EOL -> late_eol_err=1 on acceptance of the 4th beat; the 5th beat is tagged x=4.
- FIFO half-full with continuous push and pop -> count constant; reset asserted mid-stream -> valid_out=0, frame_count=0, the next beat is tagged (0,0).
- clock_en=0 for 5 cycles with valid_in=1 -> ready_out=0 and no state change; frame_count 0xFFFF plus an SOF beat -> 0x0000.
